eth_mac_pe_rx_frame_ctrl: RTL and testbench

Per-frame sequencer for the Ethernet MAC rx protocol engine. Sits between the rx byte stream (from the MAC rx core) and the rx pre-cache/data-buffer path. Parses the 14-byte Ethernet header and applies the destination-MAC filter. Forwards accepted payload bytes with a length cap, waits for the rx data buffer to finish, then issues one handle-done pulse per frame.

---
 rtl/eth_mac_pe_rx_frame_ctrl_pkg.sv | 19 +
 rtl/eth_mac_pe_rx_frame_ctrl_hdr_capture.sv | 54 +++++
 rtl/eth_mac_pe_rx_frame_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_eth_mac_pe_rx_frame_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_mac_pe_rx_frame_ctrl_pkg.sv
// Shared definitions for the rx frame sequencer: state encoding and
// Ethernet header constants.
package eth_mac_pe_rx_frame_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_HDR     = 3'd1,
      ST_PAYLOAD = 3'd2,
      ST_DISCARD = 3'd3,
      ST_WAIT_DB = 3'd4,
      ST_DONE    = 3'd5
   } rx_state_e;

   localparam int          ETH_HDR_BYTES = 14;
   localparam logic [15:0] ETHTYPE_ARP   = 16'h0806;
   localparam logic [15:0] ETHTYPE_IP    = 16'h0800;
   localparam logic [47:0] BCAST_MAC     = 48'hffff_ffff_ffff;

endpackage

// File: rtl/eth_mac_pe_rx_frame_ctrl_hdr_capture.sv
// Header capture: holds the destination MAC and ethertype high byte, plus the
// station MAC / filter enable sampled at frame start, and decodes the DA match.
module eth_mac_pe_rx_hdr_capture
   import eth_mac_pe_rx_frame_ctrl_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_clr,
   input  logic        i_we,
   input  logic        i_start,
   input  logic [3:0]  i_idx,
   input  logic [7:0]  i_byte,
   input  logic [47:0] i_sa_macaddr,
   input  logic        i_filter_en,
   output logic        o_da_match,
   output logic [15:0] o_type
);

   logic [47:0] r_da;
   logic [47:0] r_sa;
   logic        r_filter_en;
   logic [7:0]  r_type_hi;

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) begin
         r_da        <= '0;
         r_sa        <= '0;
         r_filter_en <= 1'b0;
         r_type_hi   <= '0;
      end else begin
         if (i_start) begin
            r_sa        <= i_sa_macaddr;
            r_filter_en <= i_filter_en;
         end
         if (i_we) begin
            case (i_idx)
               4'd0:    r_da[47:40] <= i_byte;
               4'd1:    r_da[39:32] <= i_byte;
               4'd2:    r_da[31:24] <= i_byte;
               4'd3:    r_da[23:16] <= i_byte;
               4'd4:    r_da[15:8]  <= i_byte;
               4'd5:    r_da[7:0]   <= i_byte;
               4'd12:   r_type_hi   <= i_byte;
               default: ;
            endcase
         end
      end
   end

   // Type low byte is the live byte 13, so the type is valid in the cycle it arrives.
   assign o_type     = {r_type_hi, i_byte};
   assign o_da_match = (r_da == r_sa) | (r_da == BCAST_MAC) | ~r_filter_en;

endmodule

// File: rtl/eth_mac_pe_rx_frame_ctrl.sv
// Per-frame rx sequencer: header parse, DA filter, capped payload forwarding,
// rx data buffer wait with timeout, and one completion pulse per frame.
//
// state   | meaning
// IDLE    | waiting for the first byte of a frame
// HDR     | collecting header bytes 1..13
// PAYLOAD | forwarding payload bytes up to the length cap
// DISCARD | DA rejected, swallowing bytes until end of frame
// WAIT_DB | waiting for rxdb_fifo_done, bounded by a timeout
// DONE    | one-cycle rx_handle_done
module eth_mac_pe_rx_frame_ctrl
   import eth_mac_pe_rx_frame_ctrl_pkg::*;
#(
   parameter int LEN_W      = 12,
   parameter int TMO_CYCLES = 1024
)(
   input  logic             pe_rx_clk,
   input  logic             pe_rx_rst,
   input  logic [7:0]       rx_frame_byte_data,
   input  logic             rx_frame_byte_data_we,
   input  logic             rx_frame_byte_data_done,
   input  logic             pe_rx_logic_clr,
   input  logic [47:0]      r_sa_macaddr,
   input  logic             r_filter_en,
   input  logic [LEN_W-1:0] r_rx_payload_byte_length,
   input  logic             rxdb_fifo_done,
   output logic             pl_byte_we,
   output logic [7:0]       pl_byte_data,
   output logic [15:0]      rx_frame_type,
   output logic             rx_frame_arp_type,
   output logic             rx_frame_ip_type,
   output logic             rx_frame_drop,
   output logic             rx_frame_err,
   output logic [LEN_W-1:0] r_rx_payload_byte_real_length,
   output logic             rx_ctrl_busy,
   output logic             rx_handle_done
);

   localparam int               TMO_W    = $clog2(TMO_CYCLES);
   localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TMO_CYCLES - 1);
   localparam logic [3:0]       HDR_LAST = 4'(ETH_HDR_BYTES - 1);

   rx_state_e        r_state;
   logic [3:0]       r_hdr_cnt;
   logic [LEN_W-1:0] r_pl_cnt;
   logic [LEN_W-1:0] r_limit;
   logic [TMO_W-1:0] r_tmo;
   logic             r_drop;
   logic             r_err;
   logic [15:0]      r_type;
   logic             r_arp;
   logic             r_ip;
   logic [LEN_W-1:0] r_real_len;
   logic             r_handle_done;

   logic             w_start;
   logic             w_hdr_we;
   logic [3:0]       w_idx;
   logic             w_hdr_last;
   logic             w_da_match;
   logic [15:0]      w_type;
   logic             w_pl_room;
   logic             w_fwd;
   logic [LEN_W-1:0] w_pl_next;
   logic [LEN_W-1:0] w_fwd_cnt;

   assign w_start    = rx_frame_byte_data_we && (r_state == ST_IDLE);
   assign w_hdr_we   = rx_frame_byte_data_we && (r_state == ST_IDLE || r_state == ST_HDR);
   assign w_idx      = (r_state == ST_IDLE) ? 4'd0 : r_hdr_cnt;
   assign w_hdr_last = rx_frame_byte_data_we && (r_state == ST_HDR) && (r_hdr_cnt == HDR_LAST);

   assign w_pl_room  = r_pl_cnt < r_limit;
   assign w_fwd      = rx_frame_byte_data_we && (r_state == ST_PAYLOAD) && w_pl_room &&
                       !pe_rx_logic_clr && !pe_rx_rst;
   assign w_pl_next  = (rx_frame_byte_data_we && !(&r_pl_cnt)) ? r_pl_cnt + LEN_W'(1) : r_pl_cnt;
   // Everything counted up to the cap was forwarded, including this cycle's byte.
   assign w_fwd_cnt  = (w_pl_next < r_limit) ? w_pl_next : r_limit;

   eth_mac_pe_rx_hdr_capture u_hdr (
      .i_clk        (pe_rx_clk),
      .i_rst        (pe_rx_rst),
      .i_clr        (pe_rx_logic_clr),
      .i_we         (w_hdr_we),
      .i_start      (w_start),
      .i_idx        (w_idx),
      .i_byte       (rx_frame_byte_data),
      .i_sa_macaddr (r_sa_macaddr),
      .i_filter_en  (r_filter_en),
      .o_da_match   (w_da_match),
      .o_type       (w_type)
   );

   always_ff @(posedge pe_rx_clk) begin
      if (pe_rx_rst || pe_rx_logic_clr) begin
         r_state       <= ST_IDLE;
         r_hdr_cnt     <= '0;
         r_pl_cnt      <= '0;
         r_limit       <= '0;
         r_tmo         <= '0;
         r_drop        <= 1'b0;
         r_err         <= 1'b0;
         r_type        <= '0;
         r_arp         <= 1'b0;
         r_ip          <= 1'b0;
         r_real_len    <= '0;
         r_handle_done <= 1'b0;
      end else begin
         r_handle_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (rx_frame_byte_data_we) begin
                  r_hdr_cnt  <= 4'd1;
                  r_pl_cnt   <= '0;
                  r_limit    <= r_rx_payload_byte_length;
                  r_drop     <= 1'b0;
                  r_type     <= '0;
                  r_arp      <= 1'b0;
                  r_ip       <= 1'b0;
                  r_real_len <= '0;
                  if (rx_frame_byte_data_done) begin
                     r_err         <= 1'b1;
                     r_handle_done <= 1'b1;
                     r_state       <= ST_DONE;
                  end else begin
                     r_err   <= 1'b0;
                     r_state <= ST_HDR;
                  end
               end
            end
            ST_HDR: begin
               if (rx_frame_byte_data_we)
                  r_hdr_cnt <= r_hdr_cnt + 4'd1;
               if (w_hdr_last) begin
                  r_type <= w_type;
                  r_arp  <= (w_type == ETHTYPE_ARP);
                  r_ip   <= (w_type == ETHTYPE_IP);
                  if (w_da_match) begin
                     if (rx_frame_byte_data_done) begin
                        r_tmo   <= TMO_LOAD;
                        r_state <= ST_WAIT_DB;
                     end else begin
                        r_state <= ST_PAYLOAD;
                     end
                  end else begin
                     r_drop <= 1'b1;
                     if (rx_frame_byte_data_done) begin
                        r_handle_done <= 1'b1;
                        r_state       <= ST_DONE;
                     end else begin
                        r_state <= ST_DISCARD;
                     end
                  end
               end else if (rx_frame_byte_data_done) begin
                  r_err         <= 1'b1;
                  r_handle_done <= 1'b1;
                  r_state       <= ST_DONE;
               end
            end
            ST_PAYLOAD: begin
               r_pl_cnt <= w_pl_next;
               if (rx_frame_byte_data_we && !w_pl_room)
                  r_err <= 1'b1;
               if (rx_frame_byte_data_done) begin
                  r_real_len <= w_fwd_cnt;
                  r_tmo      <= TMO_LOAD;
                  r_state    <= ST_WAIT_DB;
               end
            end
            ST_DISCARD: begin
               if (rx_frame_byte_data_done) begin
                  r_handle_done <= 1'b1;
                  r_state       <= ST_DONE;
               end
            end
            ST_WAIT_DB: begin
               // Timer runs down from TMO_CYCLES-1; reaching zero is the timeout.
               if (rxdb_fifo_done) begin
                  r_handle_done <= 1'b1;
                  r_state       <= ST_DONE;
               end else if (r_tmo == '0) begin
                  r_err         <= 1'b1;
                  r_handle_done <= 1'b1;
                  r_state       <= ST_DONE;
               end else begin
                  r_tmo <= r_tmo - TMO_W'(1);
               end
            end
            ST_DONE: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign pl_byte_we                    = w_fwd;
   assign pl_byte_data                  = w_fwd ? rx_frame_byte_data : 8'h00;
   assign rx_frame_type                 = r_type;
   assign rx_frame_arp_type             = r_arp;
   assign rx_frame_ip_type              = r_ip;
   assign rx_frame_drop                 = r_drop;
   assign rx_frame_err                  = r_err;
   assign r_rx_payload_byte_real_length = r_real_len;
   assign rx_ctrl_busy                  = (r_state != ST_IDLE);
   assign rx_handle_done                = r_handle_done;

endmodule

// File: tb/tb_eth_mac_pe_rx_frame_ctrl.sv
// Scoreboard bench for the rx frame sequencer: frames are generated randomly and
// with directed cases; expected bytes and completion status come from a frame-level model.
module tb_eth_mac_pe_rx_frame_ctrl;
   import eth_mac_pe_rx_frame_ctrl_pkg::*;

   localparam int LEN_W = 12;
   localparam int TMO   = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic [7:0]       data;
   logic             we;
   logic             done;
   logic             clr;
   logic             rxdb;
   logic [47:0]      cfg_mac;
   logic             cfg_filt;
   int               cfg_limit;
   logic [LEN_W-1:0] cfg_len_in;

   logic             pl_byte_we;
   logic [7:0]       pl_byte_data;
   logic [15:0]      rx_frame_type;
   logic             rx_frame_arp_type;
   logic             rx_frame_ip_type;
   logic             rx_frame_drop;
   logic             rx_frame_err;
   logic [LEN_W-1:0] real_len;
   logic             rx_ctrl_busy;
   logic             rx_handle_done;

   always #5 clk = ~clk;
   assign cfg_len_in = LEN_W'(cfg_limit);

   eth_mac_pe_rx_frame_ctrl #(.LEN_W(LEN_W), .TMO_CYCLES(TMO)) dut (
      .pe_rx_clk                     (clk),
      .pe_rx_rst                     (rst),
      .rx_frame_byte_data            (data),
      .rx_frame_byte_data_we         (we),
      .rx_frame_byte_data_done       (done),
      .pe_rx_logic_clr               (clr),
      .r_sa_macaddr                  (cfg_mac),
      .r_filter_en                   (cfg_filt),
      .r_rx_payload_byte_length      (cfg_len_in),
      .rxdb_fifo_done                (rxdb),
      .pl_byte_we                    (pl_byte_we),
      .pl_byte_data                  (pl_byte_data),
      .rx_frame_type                 (rx_frame_type),
      .rx_frame_arp_type             (rx_frame_arp_type),
      .rx_frame_ip_type              (rx_frame_ip_type),
      .rx_frame_drop                 (rx_frame_drop),
      .rx_frame_err                  (rx_frame_err),
      .r_rx_payload_byte_real_length (real_len),
      .rx_ctrl_busy                  (rx_ctrl_busy),
      .rx_handle_done                (rx_handle_done)
   );

   typedef struct {
      int               cyc;
      logic             drop;
      logic             err;
      logic [15:0]      etype;
      logic             arp;
      logic             ip;
      logic [LEN_W-1:0] len;
   } exp_t;

   exp_t       exp_done_q[$];
   logic [7:0] exp_byte_q[$];
   int         checks   = 0;
   int         failures = 0;
   int         cyc      = 0;
   exp_t       mon_e;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT forwards a byte or completes a frame.
   always @(negedge clk) begin
      if (pl_byte_we === 1'b1) begin
         if (exp_byte_q.size() == 0)
            check("pl_byte_we_unexpected", 64'(pl_byte_we), 64'd0);
         else
            check("pl_byte_data", 64'(pl_byte_data), 64'(exp_byte_q.pop_front()));
      end
      if (rx_handle_done === 1'b1) begin
         if (exp_done_q.size() == 0) begin
            check("handle_done_unexpected", 64'(rx_handle_done), 64'd0);
         end else begin
            mon_e = exp_done_q.pop_front();
            check("done_cycle",  64'(cyc),               64'(mon_e.cyc));
            check("frame_drop",  64'(rx_frame_drop),     64'(mon_e.drop));
            check("frame_err",   64'(rx_frame_err),      64'(mon_e.err));
            check("frame_type",  64'(rx_frame_type),     64'(mon_e.etype));
            check("arp_type",    64'(rx_frame_arp_type), 64'(mon_e.arp));
            check("ip_type",     64'(rx_frame_ip_type),  64'(mon_e.ip));
            check("real_length", 64'(real_len),          64'(mon_e.len));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      we = 1'b0; done = 1'b0; data = 8'h00; clr = 1'b0; rxdb = 1'b0;
   endtask

   // One frame: DA, ethertype, payload count; runt_len>0 truncates the frame
   // to that many bytes; fifo_dly<0 means rxdb_fifo_done never comes.
   task automatic run_frame(input logic [47:0] da, input logic [15:0] et, input int n_pl,
                            input int runt_len, input bit done_last, input int fifo_dly,
                            input bit gaps);
      logic [7:0] fb[$];
      int   total;
      bit   hdr_ok, match, acc;
      int   fwd;
      exp_t e;
      for (int i = 0; i < 6; i++) fb.push_back(da[47-8*i -: 8]);
      for (int i = 0; i < 6; i++) fb.push_back(8'($urandom));
      fb.push_back(et[15:8]);
      fb.push_back(et[7:0]);
      for (int i = 0; i < n_pl; i++) fb.push_back(8'($urandom));
      if (runt_len > 0)
         while (fb.size() > runt_len) void'(fb.pop_back());
      total  = fb.size();
      hdr_ok = (total >= ETH_HDR_BYTES);
      match  = (da == cfg_mac) || (da == 48'hffff_ffff_ffff) || !cfg_filt;
      acc    = hdr_ok && match;
      fwd    = (n_pl < cfg_limit) ? n_pl : cfg_limit;

      for (int i = 0; i < total; i++) begin
         if (gaps && $urandom_range(0, 3) == 0) begin
            we = 1'b0; done = 1'b0; tick();
         end
         we   = 1'b1;
         data = fb[i];
         done = done_last && (i == total - 1);
         if (acc && i >= ETH_HDR_BYTES && (i - ETH_HDR_BYTES) < cfg_limit)
            exp_byte_q.push_back(fb[i]);
         tick();
      end
      if (!done_last) begin
         we = 1'b0; data = 8'h00; done = 1'b1; tick();
      end
      idle_inputs();

      e.drop  = hdr_ok && !match;
      e.err   = !hdr_ok || (acc && n_pl > cfg_limit);
      e.etype = hdr_ok ? et : 16'h0000;
      e.arp   = hdr_ok && (et == 16'h0806);
      e.ip    = hdr_ok && (et == 16'h0800);
      e.len   = acc ? LEN_W'(fwd) : '0;
      if (!acc) begin
         e.cyc = cyc;
         exp_done_q.push_back(e);
         repeat (3) tick();
      end else if (fifo_dly < 0) begin
         e.err = 1'b1;
         e.cyc = cyc + TMO;
         exp_done_q.push_back(e);
         repeat (TMO + 3) tick();
      end else begin
         repeat (fifo_dly) tick();
         rxdb = 1'b1;
         tick();
         rxdb = 1'b0;
         e.cyc = cyc;
         exp_done_q.push_back(e);
         repeat (3) tick();
      end
   endtask

   task automatic check_all_zero(input string name);
      check(name, 64'({pl_byte_we, pl_byte_data, rx_frame_type, rx_frame_arp_type,
                       rx_frame_ip_type, rx_frame_drop, rx_frame_err, real_len,
                       rx_ctrl_busy, rx_handle_done}), 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog time limit reached checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0]  hb[14];
      logic [47:0] da;
      logic [15:0] et;
      int          pick;

      idle_inputs();
      rst       = 1'b1;
      cfg_mac   = 48'h0011_2233_4455;
      cfg_filt  = 1'b1;
      cfg_limit = 64;
      repeat (3) tick();
      rst = 1'b0;
      check_all_zero("reset_outputs");
      tick();

      // Unicast IP, broadcast ARP, filter mismatch with and without filtering.
      run_frame(48'h0011_2233_4455, 16'h0800, 8, 0, 1'b1, 3, 1'b0);
      run_frame(48'hffff_ffff_ffff, 16'h0806, 28, 0, 1'b1, 2, 1'b0);
      run_frame(48'h0011_2233_4456, 16'h0800, 12, 0, 1'b1, 0, 1'b0);
      cfg_filt = 1'b0;
      run_frame(48'h0011_2233_4456, 16'h0800, 12, 0, 1'b0, 1, 1'b0);
      cfg_filt = 1'b1;

      // Runt, truncation, zero-length payload.
      run_frame(48'h0011_2233_4455, 16'h0800, 0, 10, 1'b1, 0, 1'b0);
      cfg_limit = 4;
      run_frame(48'h0011_2233_4455, 16'h1234, 10, 0, 1'b1, 2, 1'b0);
      cfg_limit = 64;
      run_frame(48'h0011_2233_4455, 16'h0806, 0, 0, 1'b1, 1, 1'b0);

      // Abort after 5 payload bytes; the byte in the clear cycle must not be forwarded.
      for (int i = 0; i < 6; i++) hb[i] = cfg_mac[47-8*i -: 8];
      for (int i = 6; i < 12; i++) hb[i] = 8'(i);
      hb[12] = 8'h08; hb[13] = 8'h00;
      for (int i = 0; i < 14; i++) begin
         we = 1'b1; data = hb[i]; tick();
      end
      for (int i = 0; i < 5; i++) begin
         data = 8'(8'h40 + i);
         exp_byte_q.push_back(data);
         tick();
      end
      clr = 1'b1; data = 8'hAA;
      tick();
      idle_inputs();
      check("abort_busy",     64'(rx_ctrl_busy),  64'd0);
      check("abort_len",      64'(real_len),      64'd0);
      check("abort_type",     64'(rx_frame_type), 64'd0);
      repeat (2) tick();
      run_frame(48'h0011_2233_4455, 16'h0800, 6, 0, 1'b1, 2, 1'b1);

      // Data buffer never finishes: timeout.
      run_frame(48'h0011_2233_4455, 16'h0800, 5, 0, 1'b1, -1, 1'b0);

      // Randomized frames.
      for (int n = 0; n < 40; n++) begin
         cfg_mac   = {16'($urandom), 32'($urandom)};
         cfg_filt  = 1'($urandom);
         cfg_limit = $urandom_range(0, 40);
         pick      = $urandom_range(0, 2);
         if (pick == 0)      da = cfg_mac;
         else if (pick == 1) da = 48'hffff_ffff_ffff;
         else                da = cfg_mac ^ (48'd1 << $urandom_range(0, 47));
         pick = $urandom_range(0, 2);
         et   = (pick == 0) ? 16'h0800 : (pick == 1) ? 16'h0806 : 16'($urandom);
         if ($urandom_range(0, 4) == 0) begin
            done = 1'b1; tick(); done = 1'b0; tick();
         end
         run_frame(da, et, $urandom_range(0, 40),
                   ($urandom_range(0, 5) == 0) ? $urandom_range(1, 13) : 0,
                   1'($urandom),
                   ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, 8),
                   1'($urandom));
      end

      // Synchronous reset in the middle of a header.
      cfg_filt = 1'b0;
      for (int i = 0; i < 8; i++) begin
         we = 1'b1; data = 8'(i); tick();
      end
      idle_inputs();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_all_zero("midframe_reset_outputs");
      repeat (3) tick();

      check("exp_bytes_left", 64'(exp_byte_q.size()), 64'd0);
      check("exp_done_left",  64'(exp_done_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
